// File: rtl/neurosa_pkg.sv
// Shared definitions for the spike event path.
// Contents:
//   SPIKE_ADDR_W / SPIKE_DATA_W / SPIKE_BUF_DEPTH : default event geometry
//   spike_event_t : packed {addr, data} event, addr in the MSBs
//   buf_state_t   : timestep sequencing states of spike_event_buffer
package neurosa_pkg;

  localparam int SPIKE_ADDR_W    = 10;
  localparam int SPIKE_DATA_W    = 2;
  localparam int SPIKE_BUF_DEPTH = 16;

  typedef struct packed {
    logic [SPIKE_ADDR_W-1:0] addr;
    logic [SPIKE_DATA_W-1:0] data;
  } spike_event_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_FLUSH   = 2'd2
  } buf_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO.
// Ports:
//   clk, reset     : clock, asynchronous active-high reset (clears pointers/count)
//   push, wr_data  : write request; taken when not full, or full with a pop
//   pop            : read request; taken when not empty
//   rd_data        : head entry, forced to 0 while empty
//   full, empty    : status
//   count          : occupancy, 0..DEPTH
module sync_fifo #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW:0]      count_reg;
  logic             wr_en;
  logic             rd_en;

  assign full  = (count_reg == (AW+1)'(DEPTH));
  assign empty = (count_reg == '0);
  assign count = count_reg;

  // When full, a same-cycle pop frees the slot the write lands in
  // (wr_ptr == rd_ptr); the head is read combinationally before the edge.
  assign rd_en = pop && !empty;
  assign wr_en = push && (!full || rd_en);

  assign rd_data = empty ? '0 : mem[rd_ptr_reg];

  // Storage has no reset; stale contents are never visible because
  // rd_data is masked while empty.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr_reg] <= wr_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (wr_en) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (rd_en) rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/spike_event_buffer.sv
// Spike event buffer: captures non-zero spike events from the upstream mux
// network into a FIFO and streams them over a valid/ready channel, framing
// each timestep (ev_last on the final event, timestep_done once drained).
// Optional feature: define SPIKE_BUF_DROP_CNT_EN to build the saturating
// drop counter; otherwise drop_count is tied to 0.
// Ports:
//   clk, reset        : clock, asynchronous active-high reset
//   en_capture        : qualifies spike_in sampling
//   spike_in          : {addr, data}; data==0 means no spike
//   network_done      : upstream end-of-timestep pulse
//   ev_valid/ev_ready : downstream handshake; ev_addr/ev_data = FIFO head
//   ev_last           : final event of the timestep (during flush)
//   buf_full/buf_empty: FIFO status
//   drop_count        : events offered but refused (saturating)
//   timestep_done     : one-cycle pulse when the flush has completed
module spike_event_buffer
  import neurosa_pkg::*;
#(
  parameter int SPIKE_OUT_ADDR = SPIKE_ADDR_W,
  parameter int SPIKE_OUT_DATA = SPIKE_DATA_W,
  parameter int BUF_DEPTH      = SPIKE_BUF_DEPTH
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               en_capture,
  input  logic [SPIKE_OUT_ADDR+SPIKE_OUT_DATA-1:0] spike_in,
  input  logic                               network_done,
  output logic                               ev_valid,
  output logic [SPIKE_OUT_ADDR-1:0]          ev_addr,
  output logic [SPIKE_OUT_DATA-1:0]          ev_data,
  input  logic                               ev_ready,
  output logic                               ev_last,
  output logic                               buf_full,
  output logic                               buf_empty,
  output logic [15:0]                        drop_count,
  output logic                               timestep_done
);

  localparam int EW = SPIKE_OUT_ADDR + SPIKE_OUT_DATA;
  localparam int CW = $clog2(BUF_DEPTH) + 1;

  buf_state_t     state_reg;
  buf_state_t     state_next;
  logic [EW-1:0]  head;
  logic [CW-1:0]  count;
  logic           offer;
  logic           pop;

  // Captures are refused during a flush so the timestep can close.
  assign offer = en_capture && (spike_in[SPIKE_OUT_DATA-1:0] != '0)
               && (state_reg != ST_FLUSH);
  assign pop   = ev_valid && ev_ready;

  sync_fifo #(
    .WIDTH (EW),
    .DEPTH (BUF_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (offer),
    .wr_data (spike_in),
    .pop     (pop),
    .rd_data (head),
    .full    (buf_full),
    .empty   (buf_empty),
    .count   (count)
  );

  assign ev_valid = !buf_empty;
  assign ev_addr  = head[EW-1:SPIKE_OUT_DATA];
  assign ev_data  = head[SPIKE_OUT_DATA-1:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_reg <= ST_IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next    = state_reg;
    timestep_done = 1'b0;
    ev_last       = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (en_capture) state_next = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        if (network_done) state_next = ST_FLUSH;
      end
      ST_FLUSH: begin
        ev_last = ev_valid && (count == CW'(1));
        if (count == '0) begin
          state_next    = ST_IDLE;
          timestep_done = 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

`ifdef SPIKE_BUF_DROP_CNT_EN
  logic        drop;
  logic [15:0] drop_cnt_reg;

  // Mirrors the FIFO's own acceptance rule: full blocks unless a pop
  // frees a slot this cycle.
  assign drop = offer && buf_full && !pop;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                drop_cnt_reg <= '0;
    else if (drop && drop_cnt_reg != 16'hFFFF) drop_cnt_reg <= drop_cnt_reg + 1'b1;
  end

  assign drop_count = drop_cnt_reg;
`else
  assign drop_count = '0;
`endif

endmodule

// File: tb/tb_spike_event_buffer.sv
module tb_spike_event_buffer;
  import neurosa_pkg::*;

  localparam int DEPTH = 16;
`ifdef SPIKE_BUF_DROP_CNT_EN
  localparam int EXP_DROP1 = 1;
`else
  localparam int EXP_DROP1 = 0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        en_capture = 1'b0;
  logic [11:0] spike_in = '0;
  logic        network_done = 1'b0;
  logic        ev_valid;
  logic [9:0]  ev_addr;
  logic [1:0]  ev_data;
  logic        ev_ready = 1'b0;
  logic        ev_last;
  logic        buf_full;
  logic        buf_empty;
  logic [15:0] drop_count;
  logic        timestep_done;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  spike_event_buffer dut (
    .clk           (clk),
    .reset         (reset),
    .en_capture    (en_capture),
    .spike_in      (spike_in),
    .network_done  (network_done),
    .ev_valid      (ev_valid),
    .ev_addr       (ev_addr),
    .ev_data       (ev_data),
    .ev_ready      (ev_ready),
    .ev_last       (ev_last),
    .buf_full      (buf_full),
    .buf_empty     (buf_empty),
    .drop_count    (drop_count),
    .timestep_done (timestep_done)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Timestep phase: 0 idle, 1 capturing, 2 flushing.
  logic [11:0] mq[$];
  int          m_drop  = 0;
  int          m_phase = 0;
  logic [11:0] got[$];

  always @(posedge clk or posedge reset) begin
    int sz;
    bit offer, pop, acc;
    if (reset) begin
      mq.delete();
      m_drop  = 0;
      m_phase = 0;
    end else begin
      sz    = mq.size();
      offer = en_capture && (spike_in[1:0] != 2'b00) && (m_phase != 2);
      pop   = (sz > 0) && ev_ready;
      acc   = offer && ((sz < DEPTH) || pop);
      if (pop) void'(mq.pop_front());
      if (acc) mq.push_back(spike_in);
`ifdef SPIKE_BUF_DROP_CNT_EN
      if (offer && !acc && m_drop < 65535) m_drop++;
`endif
      if (m_phase == 0 && en_capture) m_phase = 1;
      else if (m_phase == 1 && network_done) m_phase = 2;
      else if (m_phase == 2 && sz == 0) m_phase = 0;
    end
  end

  // Compare every cycle, away from the active edge.
  always @(negedge clk) begin
    logic [11:0] h;
    h = (mq.size() > 0) ? mq[0] : 12'h000;
    chk("ev_valid", ev_valid, mq.size() > 0);
    chk("ev_addr", ev_addr, h[11:2]);
    chk("ev_data", ev_data, h[1:0]);
    chk("buf_empty", buf_empty, mq.size() == 0);
    chk("buf_full", buf_full, mq.size() == DEPTH);
    chk("ev_last", ev_last, (m_phase == 2) && (mq.size() == 1));
    chk("timestep_done", timestep_done, (m_phase == 2) && (mq.size() == 0));
    chk("drop_count", drop_count, m_drop);
    if (ev_valid && ev_ready && !reset) begin
      got.push_back({ev_addr, ev_data});
      $display("EV addr=%0d data=%0d last=%0b t=%0t", ev_addr, ev_data, ev_last, $time);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int addr, input int data);
    spike_event_t ev;
    ev.addr = 10'(addr);
    ev.data = 2'(data);
    spike_in = ev;
  endtask

  initial begin
    int beats, last_at, td, n_got;
    repeat (3) tick;
    @(negedge clk);
    chk("rst_ev_valid", ev_valid, 0);
    chk("rst_buf_empty", buf_empty, 1);
    chk("rst_drop", drop_count, 0);
    tick;
    reset = 1'b0;

    // Three events streamed with ready high, each visible one cycle after capture.
    ev_ready = 1'b1; en_capture = 1'b1; send(5, 1);
    tick; send(7, 1);
    @(negedge clk); chk("t1_beat0", {ev_valid, ev_addr}, {1'b1, 10'd5});
    tick; send(9, 1);
    @(negedge clk); chk("t1_beat1", {ev_valid, ev_addr}, {1'b1, 10'd7});
    tick; en_capture = 1'b0; send(0, 0);
    @(negedge clk); chk("t1_beat2", {ev_valid, ev_addr}, {1'b1, 10'd9});
    tick;
    @(negedge clk); chk("t1_empty", buf_empty, 1);
    chk("t1_count", got.size(), 3);
    if (got.size() == 3) begin
      chk("t1_order0", got[0], {10'd5, 2'd1});
      chk("t1_order2", got[2], {10'd9, 2'd1});
    end

    // network_done with empty FIFO: timestep_done the following cycle.
    network_done = 1'b1;
    tick; network_done = 1'b0;
    @(negedge clk); chk("t5_td_pulse", timestep_done, 1);
    tick;
    @(negedge clk); chk("t5_td_low", timestep_done, 0);

    // Zero payload never pushes.
    en_capture = 1'b1; send(3, 0);
    tick; en_capture = 1'b0;
    @(negedge clk); chk("t5_zero_nopush", buf_empty, 1);

    // Fill 16 with ready low, then a 17th is dropped.
    ev_ready = 1'b0; en_capture = 1'b1;
    for (int i = 0; i < 16; i++) begin
      send(100 + i, 2);
      tick;
    end
    @(negedge clk); chk("t2_full", buf_full, 1);
    send(200, 2);
    tick;
    @(negedge clk);
    chk("t2_drop", drop_count, EXP_DROP1);
    chk("t2_head", ev_addr, 100);

    // Full with simultaneous push and pop: push accepted, stays full.
    send(201, 2); ev_ready = 1'b1;
    tick; en_capture = 1'b0; ev_ready = 1'b0; send(0, 0);
    @(negedge clk);
    chk("t3_still_full", buf_full, 1);
    chk("t3_drop_same", drop_count, EXP_DROP1);
    chk("t3_head", ev_addr, 101);

    // Drain, bounded.
    ev_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick;
      @(negedge clk);
      if (buf_empty) break;
    end
    chk("drain_empty", buf_empty, 1);
    chk("drain_last_addr", got[got.size()-1], {10'd201, 2'd2});
    tick; ev_ready = 1'b0;

    // Two buffered events, network_done, then drain: ev_last on 2nd beat.
    en_capture = 1'b1; send(20, 1);
    tick; send(21, 3);
    tick; en_capture = 1'b0; send(0, 0); network_done = 1'b1;
    tick; network_done = 1'b0; ev_ready = 1'b1;
    beats = 0; last_at = 0; td = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (ev_valid) begin
        beats++;
        if (ev_last) last_at = beats;
      end
      if (timestep_done) td++;
      tick;
    end
    chk("t4_beats", beats, 2);
    chk("t4_last_beat", last_at, 2);
    chk("t4_td_once", td, 1);
    chk("t4_state_idle", 32'(dut.state_reg), 32'(ST_IDLE));

    // Reset with 5 buffered events and ready low.
    ev_ready = 1'b0; en_capture = 1'b1;
    for (int i = 0; i < 5; i++) begin
      send(40 + i, 1);
      tick;
    end
    en_capture = 1'b0; send(0, 0);
    #1;
    chk("t6_pre_valid", ev_valid, 1);
    reset = 1'b1;
    #1;
    chk("t6_async_valid", ev_valid, 0);
    chk("t6_async_empty", buf_empty, 1);
    tick; tick;
    reset = 1'b0; ev_ready = 1'b1;
    n_got = got.size();
    repeat (5) tick;
    chk("t6_no_events", got.size(), n_got);
    chk("t6_empty_after", buf_empty, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
